// File: rtl/lb_uart_rx_host_ctrl.sv
// KCPSM-facing host controller for the UART receive path:
// config registers, 10-bit receive FIFO, status and interrupt.
module lb_uart_rx_host_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter int         FIFO_AW   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  port_id,
  input  logic        write_strobe,
  input  logic        read_strobe,
  input  logic [7:0]  out_port,
  output logic [7:0]  in_port,
  output logic        interrupt,
  input  logic        interrupt_ack,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  input  logic        rx_perr,
  input  logic        rx_ferr,
  output logic        rx_en,
  output logic        cfg_bit8,
  output logic        cfg_parity_en,
  output logic [19:0] cfg_baud_prescale
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    WAIT
  } irq_st_t;

  irq_st_t st_q, st_d;

  logic [9:0]         mem_q [DEPTH];
  logic [9:0]         mem_d [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovr_q, ovr_d;
  logic               rx_en_q, rx_en_d;
  logic               ie_q, ie_d;
  logic               par_q, par_d;
  logic               bit8_q, bit8_d;
  logic [7:0]         stg0_q, stg0_d;
  logic [7:0]         stg1_q, stg1_d;
  logic [19:0]        baud_q, baud_d;
  logic [7:0]         in_port_q, in_port_d;

  logic [7:0] off;
  logic [5:0] sel;
  logic [9:0] head;
  logic       nempty;
  logic       full;
  logic       pop;
  logic       push;
  logic       push_ok;
  logic       cfg_open;

  // Unsigned wrap makes any port_id below BASE_ADDR land out of range.
  assign off = port_id - BASE_ADDR;

  always_comb begin
    sel = '0;
    for (int i = 0; i < 6; i++) begin
      sel[i] = (off == 8'(i));
    end
  end

  assign head     = mem_q[rptr_q];
  assign nempty   = (cnt_q != '0);
  assign full     = (cnt_q == FULL_CNT);
  assign pop      = read_strobe & sel[0] & nempty;
  assign push     = rx_done & rx_en_q;
  assign push_ok  = push & (~full | pop);
  assign cfg_open = ~rx_en_q;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovr_d  = ovr_q;
    if (push_ok) begin
      mem_d[wptr_q] = {rx_ferr, rx_perr, rx_data};
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    if (write_strobe && sel[1] && out_port[4]) begin
      ovr_d = 1'b0;
    end
    if (push && full && !pop) begin
      ovr_d = 1'b1;
    end
  end

  always_comb begin
    rx_en_d = rx_en_q;
    ie_d    = ie_q;
    par_d   = par_q;
    bit8_d  = bit8_q;
    stg0_d  = stg0_q;
    stg1_d  = stg1_q;
    baud_d  = baud_q;
    if (write_strobe && sel[2]) begin
      rx_en_d = out_port[7];
      ie_d    = out_port[2];
      // Disabling the receiver in the same write unlocks the format bits.
      if (cfg_open || !out_port[7]) begin
        par_d  = out_port[1];
        bit8_d = out_port[0];
      end
    end
    if (write_strobe && cfg_open) begin
      if (sel[3]) stg0_d = out_port;
      if (sel[4]) stg1_d = out_port;
      if (sel[5]) baud_d = {out_port[3:0], stg1_q, stg0_q};
    end
  end

  always_comb begin
    in_port_d = 8'h00;
    unique case (1'b1)
      sel[0]: in_port_d = nempty ? head[7:0] : 8'h00;
      sel[1]: in_port_d = {3'b000, ovr_q, nempty & head[9],
                           nempty & head[8], full, nempty};
      sel[2]: in_port_d = {rx_en_q, 4'b0000, ie_q, par_q, bit8_q};
      sel[3]: in_port_d = baud_q[7:0];
      sel[4]: in_port_d = baud_q[15:8];
      sel[5]: in_port_d = {4'b0000, baud_q[19:16]};
      default: in_port_d = 8'h00;
    endcase
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: if (ie_q && (nempty || ovr_q)) st_d = PEND;
      PEND: if (interrupt_ack) st_d = WAIT;
      WAIT: if (!nempty && !ovr_q) st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (!ie_d) begin
      st_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= IDLE;
      mem_q     <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
      rx_en_q   <= 1'b0;
      ie_q      <= 1'b0;
      par_q     <= 1'b0;
      bit8_q    <= 1'b1;
      stg0_q    <= '0;
      stg1_q    <= '0;
      baud_q    <= '0;
      in_port_q <= '0;
    end else begin
      st_q      <= st_d;
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
      rx_en_q   <= rx_en_d;
      ie_q      <= ie_d;
      par_q     <= par_d;
      bit8_q    <= bit8_d;
      stg0_q    <= stg0_d;
      stg1_q    <= stg1_d;
      baud_q    <= baud_d;
      in_port_q <= in_port_d;
    end
  end

  assign in_port           = in_port_q;
  assign interrupt         = (st_q == PEND);
  assign rx_en             = rx_en_q;
  assign cfg_bit8          = bit8_q;
  assign cfg_parity_en     = par_q;
  assign cfg_baud_prescale = baud_q;

endmodule

// File: tb/tb_lb_uart_rx_host_ctrl.sv
// Directed table-driven bench for lb_uart_rx_host_ctrl.
// Each vector drives one cycle, then checks selected outputs.
module tb_lb_uart_rx_host_ctrl;

  localparam logic [7:0] A_DATA = 8'h10;
  localparam logic [7:0] A_STAT = 8'h11;
  localparam logic [7:0] A_CTRL = 8'h12;
  localparam logic [7:0] A_B0   = 8'h13;
  localparam logic [7:0] A_B1   = 8'h14;
  localparam logic [7:0] A_B2   = 8'h15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  port_id = '0;
  logic        write_strobe = 1'b0;
  logic        read_strobe = 1'b0;
  logic [7:0]  out_port = '0;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_perr = 1'b0;
  logic        rx_ferr = 1'b0;
  logic        rx_en;
  logic        cfg_bit8;
  logic        cfg_parity_en;
  logic [19:0] cfg_baud_prescale;

  lb_uart_rx_host_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .port_id           (port_id),
    .write_strobe      (write_strobe),
    .read_strobe       (read_strobe),
    .out_port          (out_port),
    .in_port           (in_port),
    .interrupt         (interrupt),
    .interrupt_ack     (interrupt_ack),
    .rx_done           (rx_done),
    .rx_data           (rx_data),
    .rx_perr           (rx_perr),
    .rx_ferr           (rx_ferr),
    .rx_en             (rx_en),
    .cfg_bit8          (cfg_bit8),
    .cfg_parity_en     (cfg_parity_en),
    .cfg_baud_prescale (cfg_baud_prescale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [7:0]  wd;
    logic        rx;
    logic [7:0]  rb;
    logic        pe;
    logic        fe;
    logic        ack;
    logic [3:0]  m;
    logic [7:0]  ein;
    logic        eirq;
    logic        een;
    logic [19:0] eb;
  } vec_t;

  vec_t tv[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t nv();
    vec_t v;
    v.wr = 0; v.rd = 0; v.addr = 8'h00; v.wd = 8'h00;
    v.rx = 0; v.rb = 8'h00; v.pe = 0; v.fe = 0; v.ack = 0;
    v.m = 4'b0000; v.ein = 8'h00; v.eirq = 0;
    v.een = 0; v.eb = 20'h0;
    return v;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [19:0] a, input logic [19:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s vec%0d got %h want %h", nm, i, a, e);
    end
  endtask

  task automatic nop();
    tv.push_back(nv());
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    vec_t v = nv();
    v.wr = 1; v.addr = a; v.wd = d;
    tv.push_back(v);
  endtask

  task automatic pk(input logic [7:0] a, input logic [7:0] e);
    vec_t v = nv();
    v.addr = a; v.m[0] = 1; v.ein = e;
    tv.push_back(v);
  endtask

  task automatic rd(input logic [7:0] e);
    vec_t v = nv();
    v.rd = 1; v.addr = A_DATA; v.m[0] = 1; v.ein = e;
    tv.push_back(v);
  endtask

  task automatic rx(input logic [7:0] b, input logic pe,
                    input logic fe);
    vec_t v = nv();
    v.rx = 1; v.rb = b; v.pe = pe; v.fe = fe;
    tv.push_back(v);
  endtask

  task automatic also_rx(input logic [7:0] b);
    vec_t v = tv.pop_back();
    v.rx = 1; v.rb = b;
    tv.push_back(v);
  endtask

  task automatic also_ack();
    vec_t v = tv.pop_back();
    v.ack = 1;
    tv.push_back(v);
  endtask

  task automatic ci(input logic e);
    vec_t v = tv.pop_back();
    v.m[1] = 1; v.eirq = e;
    tv.push_back(v);
  endtask

  task automatic ce(input logic e);
    vec_t v = tv.pop_back();
    v.m[2] = 1; v.een = e;
    tv.push_back(v);
  endtask

  task automatic cb(input logic [19:0] e);
    vec_t v = tv.pop_back();
    v.m[3] = 1; v.eb = e;
    tv.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    write_strobe  = v.wr;
    read_strobe   = v.rd;
    port_id       = v.addr;
    out_port      = v.wd;
    rx_done       = v.rx;
    rx_data       = v.rb;
    rx_perr       = v.pe;
    rx_ferr       = v.fe;
    interrupt_ack = v.ack;
  endtask

  initial begin
    // Config and baud staging
    pk(A_CTRL, 8'h01);
    wr(A_B0, 8'h34); cb(20'h0);
    wr(A_B1, 8'h12); cb(20'h0);
    wr(A_B2, 8'h05); cb(20'h51234);
    pk(A_B2, 8'h05);
    pk(A_B0, 8'h34);
    wr(A_CTRL, 8'h87); ce(1'b1); ci(1'b0);
    wr(A_B2, 8'h0F); cb(20'h51234);
    wr(A_CTRL, 8'h84);
    pk(A_CTRL, 8'h87);
    // Single receive with parity error
    rx(8'hA5, 1'b1, 1'b0); ci(1'b0);
    pk(A_STAT, 8'h05); ci(1'b1);
    rd(8'hA5); ci(1'b1);
    pk(A_STAT, 8'h00);
    nop(); also_ack(); ci(1'b0);
    nop(); ci(1'b0);
    // Overrun with IE off
    wr(A_CTRL, 8'h80); ce(1'b1);
    rx(8'h01, 0, 0);
    rx(8'h02, 0, 0);
    rx(8'h03, 0, 0);
    rx(8'h04, 0, 0);
    rx(8'h05, 0, 0);
    pk(A_STAT, 8'h13); ci(1'b0);
    rd(8'h01);
    rd(8'h02);
    rd(8'h03);
    rd(8'h04);
    pk(A_STAT, 8'h10);
    wr(A_STAT, 8'h10);
    pk(A_STAT, 8'h00);
    rd(8'h00);
    pk(A_STAT, 8'h00);
    // Push and pop together while full
    rx(8'h11, 0, 0);
    rx(8'h22, 0, 1);
    rx(8'h33, 0, 0);
    rx(8'h44, 0, 0);
    rd(8'h11); also_rx(8'h55);
    pk(A_STAT, 8'h0B);
    rd(8'h22);
    rd(8'h33);
    rd(8'h44);
    rd(8'h55);
    pk(A_STAT, 8'h00);
    // Interrupt ack / drain / re-arm
    wr(A_CTRL, 8'h84); ci(1'b0);
    rx(8'hC1, 0, 0); ci(1'b0);
    rx(8'hC2, 0, 0); ci(1'b1);
    rx(8'hC3, 0, 0); also_ack(); ci(1'b0);
    rd(8'hC1); ci(1'b0);
    nop(); ci(1'b0);
    rd(8'hC2); ci(1'b0);
    rd(8'hC3); ci(1'b0);
    nop(); ci(1'b0);
    rx(8'hD0, 0, 0); ci(1'b0);
    nop(); ci(1'b1);
    wr(A_CTRL, 8'h80); ci(1'b0);
    // Disable receiver: format bits apply, rx_done ignored
    wr(A_CTRL, 8'h00); ce(1'b0);
    rx(8'hEE, 0, 0);
    pk(A_STAT, 8'h01);
    rd(8'hD0);
    pk(A_STAT, 8'h00);
    pk(A_CTRL, 8'h00);
    pk(8'h16, 8'h00);
    // Load two bytes ahead of the mid-operation reset
    wr(A_CTRL, 8'h85); ce(1'b1);
    rx(8'h71, 0, 0);
    rx(8'h72, 0, 0); ci(1'b1);
    pk(A_STAT, 8'h01); cb(20'h51234);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_port", -1, 20'(in_port), 20'h0);
    chk("rst_irq", -1, 20'(interrupt), 20'h0);
    chk("rst_rx_en", -1, 20'(rx_en), 20'h0);
    chk("rst_bit8", -1, 20'(cfg_bit8), 20'h1);
    chk("rst_par", -1, 20'(cfg_parity_en), 20'h0);
    chk("rst_baud", -1, cfg_baud_prescale, 20'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i]);
      @(posedge clk);
      #1;
      if (tv[i].m[0]) chk("in_port", i, 20'(in_port), 20'(tv[i].ein));
      if (tv[i].m[1]) chk("irq", i, 20'(interrupt), 20'(tv[i].eirq));
      if (tv[i].m[2]) chk("rx_en", i, 20'(rx_en), 20'(tv[i].een));
      if (tv[i].m[3]) chk("baud", i, cfg_baud_prescale, tv[i].eb);
    end
    @(negedge clk);
    drive(nv());

    // Asynchronous reset between edges, FIFO holding two bytes
    port_id = A_CTRL;
    rx_done = 1'b1;
    rx_data = 8'h73;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_irq", -2, 20'(interrupt), 20'h0);
    chk("mid_rx_en", -2, 20'(rx_en), 20'h0);
    chk("mid_baud", -2, cfg_baud_prescale, 20'h0);
    chk("mid_in_port", -2, 20'(in_port), 20'h0);
    chk("mid_bit8", -2, 20'(cfg_bit8), 20'h1);
    @(negedge clk);
    drive(nv());
    reset = 1'b0;
    port_id = A_STAT;
    @(posedge clk);
    #1;
    chk("mid_status", -2, 20'(in_port), 20'h0);
    @(negedge clk);
    port_id = A_CTRL;
    @(posedge clk);
    #1;
    chk("mid_ctrl", -2, 20'(in_port), 20'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
